// File: rtl/vmem_scanout_pkg.sv
// Shared constants for the display scan-out path:
// FSM encodings, RGB565 field layout and the 3-bit colour expansion.
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 14
`endif

package vmem_scanout_pkg;

    localparam int VMEM_ADDRW_DEF = `VMEM_ADDRW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PIX_IN_W  = 3;
    localparam int PIX_OUT_W = 16;
    localparam int R_W       = 5;
    localparam int G_W       = 6;
    localparam int B_W       = 5;
    localparam int R_LSB     = G_W + B_W;
    localparam int G_LSB     = B_W;
    localparam int B_LSB     = 0;

    // FIFO entry: {rgb565, sof, eol}
    localparam int ENTRY_W = PIX_OUT_W + 2;

    function automatic logic [PIX_OUT_W-1:0] rgb565_expand(
        input logic [PIX_IN_W-1:0] d
    );
        rgb565_expand = {{R_W{d[2]}}, {G_W{d[1]}}, {B_W{d[0]}}};
    endfunction

endpackage

// File: rtl/scan_fifo2.sv
// Two-entry synchronous FIFO with occupancy output.
// Head data is presented combinationally from the read pointer.
module scan_fifo2 #(
    parameter int W = 18
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage, pointers and count; push and pop may coincide
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vmem_scanout.sv
// Raster-order frame buffer reader feeding an RGB565 valid/ready stream.
// Reads are credit-limited so the 2-entry FIFO can always absorb returns.
module vmem_scanout
    import vmem_scanout_pkg::*;
#(
    parameter int VMEM_ADDRW = VMEM_ADDRW_DEF,
    parameter int H_PIXELS   = 128,
    parameter int V_PIXELS   = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic [VMEM_ADDRW-1:0] disp_raddr_o,
    input  logic [PIX_IN_W-1:0]   disp_rdata_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [PIX_OUT_W-1:0]  pix_data_o,
    output logic                  pix_sof_o,
    output logic                  pix_eol_o,
    output logic                  busy_o
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [VMEM_ADDRW-1:0] addr_q;
    logic                  inflight_q;
    logic                  sof_q;
    logic                  eol_q;
    logic [1:0]            fifo_cnt;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [1:0]            occ;
    logic                  pop;
    logic                  issue;
    logic                  last_x;
    logic                  last_y;
    logic                  drained;

    assign last_x  = (x_q == XW'(H_PIXELS - 1));
    assign last_y  = (y_q == YW'(V_PIXELS - 1));
    assign pop     = pix_valid_o && pix_ready_i;
    // Credit counts the slot freed by this cycle's pop, which sustains
    // one read per cycle while the consumer keeps up.
    assign occ     = fifo_cnt - {1'b0, pop} + {1'b0, inflight_q};
    assign issue   = (state_q == ST_SCAN) && (occ < 2'd2);
    assign drained = !inflight_q && (fifo_cnt == 2'd0);

    // Next-state selection for the scan sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (issue && last_x && last_y) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained) state_d = enable_i ? ST_SCAN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, raster counters, linear address and in-flight read tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                sof_q <= (x_q == '0) && (y_q == '0);
                eol_q <= last_x;
                if (last_x) begin
                    x_q <= '0;
                    if (last_y) begin
                        y_q    <= '0;
                        addr_q <= '0;
                    end else begin
                        y_q    <= y_q + YW'(1);
                        addr_q <= addr_q + VMEM_ADDRW'(1);
                    end
                end else begin
                    x_q    <= x_q + XW'(1);
                    addr_q <= addr_q + VMEM_ADDRW'(1);
                end
            end
        end
    end

    assign fifo_din = {rgb565_expand(disp_rdata_i), sof_q, eol_q};

    scan_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (inflight_q),
        .din_i  (fifo_din),
        .pop_i  (pop),
        .dout_o (fifo_head),
        .count_o(fifo_cnt)
    );

    assign disp_raddr_o = addr_q;
    assign pix_valid_o  = (fifo_cnt != 2'd0);
    assign pix_data_o   = fifo_head[ENTRY_W-1:2];
    assign pix_sof_o    = fifo_head[1];
    assign pix_eol_o    = fifo_head[0];
    assign busy_o       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_vmem_scanout.sv
// Directed bench for vmem_scanout with a pixel-index reference model
// and a per-cycle stream checker.
module tb_vmem_scanout;

    localparam int H     = 128;
    localparam int V     = 128;
    localparam int FRAME = H * V;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic [AW-1:0] disp_raddr_o;
    logic [2:0]    disp_rdata_i;
    logic          pix_valid_o;
    logic          pix_ready_i;
    logic [15:0]   pix_data_o;
    logic          pix_sof_o;
    logic          pix_eol_o;
    logic          busy_o;

    vmem_scanout #(
        .VMEM_ADDRW(AW),
        .H_PIXELS  (H),
        .V_PIXELS  (V)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .disp_raddr_o(disp_raddr_o),
        .disp_rdata_i(disp_rdata_i),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .pix_data_o  (pix_data_o),
        .pix_sof_o   (pix_sof_o),
        .pix_eol_o   (pix_eol_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Synchronous video memory, preloaded with addr[2:0]
    logic [2:0] vmem [FRAME];
    initial begin
        for (int i = 0; i < FRAME; i++) vmem[i] = 3'(i % 8);
    end
    always @(posedge clk) disp_rdata_i <= vmem[disp_raddr_o];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected pixel n of a frame: colour channels are full-on when the
    // matching bit of the stored 3-bit value (n mod 8) is set.
    function automatic logic [15:0] exp_pix(input int idx);
        logic [15:0] v;
        int          c;
        c = idx % 8;
        v = 16'h0000;
        if (c >= 4)     v = v | 16'hF800;
        if (c % 4 >= 2) v = v | 16'h07E0;
        if (c % 2 == 1) v = v | 16'h001F;
        return v;
    endfunction

    int          n = 0;
    int          frames_done = 0;
    int          accepted = 0;
    int          eol_cnt = 0;
    int          cyc = 0;
    int          sof_cyc = 0;
    int          last_cyc = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d;
    logic        hold_s;
    logic        hold_e;

    // Stream checker, sampled mid-cycle
    always @(negedge clk) begin
        int d;
        cyc++;
        if (rst_i) begin
            n      = 0;
            hold_v = 1'b0;
        end else begin
            d = (int'(disp_raddr_o) + FRAME - n) % FRAME;
            chk("read_lead", 32'(d <= 2), 32'd1);
            if (hold_v) begin
                chk("hold_valid", 32'(pix_valid_o), 32'd1);
                chk("hold_data", 32'(pix_data_o), 32'(hold_d));
                chk("hold_sof", 32'(pix_sof_o), 32'(hold_s));
                chk("hold_eol", 32'(pix_eol_o), 32'(hold_e));
            end
            if (pix_valid_o) begin
                chk("data", 32'(pix_data_o), 32'(exp_pix(n)));
                chk("sof", 32'(pix_sof_o), 32'(n == 0));
                chk("eol", 32'(pix_eol_o), 32'(n % H == H - 1));
                if (frames_done == 0 && n == 1) chk("pin1", 32'(pix_data_o), 32'h001F);
                if (frames_done == 0 && n == 2) chk("pin2", 32'(pix_data_o), 32'h07E0);
                if (frames_done == 0 && n == 4) chk("pin4", 32'(pix_data_o), 32'hF800);
                if (frames_done == 0 && n == 7) chk("pin7", 32'(pix_data_o), 32'hFFFF);
                if (pix_sof_o && !hold_v) sof_cyc = cyc;
                if (pix_ready_i) begin
                    accepted++;
                    if (pix_eol_o) eol_cnt++;
                    n++;
                    if (n == FRAME) begin
                        n        = 0;
                        last_cyc = cyc;
                        frames_done++;
                    end
                end
            end
            hold_v = pix_valid_o && !pix_ready_i;
            hold_d = pix_data_o;
            hold_s = pix_sof_o;
            hold_e = pix_eol_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enable();
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
    endtask

    task automatic wait_pix(input int v, input int bound, input string nm);
        int k;
        k = 0;
        while (n != v && k < bound) begin
            step();
            k++;
        end
        if (n != v) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic wait_frames(input int f, input int bound, input string nm);
        int k;
        k = 0;
        while (frames_done < f && k < bound) begin
            step();
            k++;
        end
        if (frames_done < f) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k;
        k = 0;
        while (busy_o && k < bound) begin
            step();
            k++;
        end
        chk(nm, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int          k;
        logic [AW-1:0] r0;
        rst_i       = 1'b1;
        enable_i    = 1'b0;
        pix_ready_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(pix_valid_o), 32'd0);
        chk("rst_addr", 32'(disp_raddr_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_data", 32'(pix_data_o), 32'd0);
        chk("rst_sof", 32'(pix_sof_o), 32'd0);
        chk("rst_eol", 32'(pix_eol_o), 32'd0);

        // Frame 1: single-cycle enable, consumer always ready
        step();
        pulse_enable();
        @(negedge clk);
        chk("lat0_valid", 32'(pix_valid_o), 32'd0);
        chk("lat0_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("lat1_valid", 32'(pix_valid_o), 32'd0);
        @(negedge clk);
        chk("lat2_valid", 32'(pix_valid_o), 32'd1);
        chk("lat2_sof", 32'(pix_sof_o), 32'd1);
        chk("lat2_data", 32'(pix_data_o), 32'h0000);
        chk("lat2_addr", 32'(disp_raddr_o), 32'd2);
        step();
        wait_frames(1, FRAME + 100, "timeout_frame1");
        chk("f1_count", 32'(accepted), 32'd16384);
        chk("f1_eols", 32'(eol_cnt), 32'd128);
        chk("f1_no_bubble", 32'(last_cyc - sof_cyc), 32'd16383);
        wait_idle(10, "f1_busy_fall");
        for (int i = 0; i < 5; i++) step();
        chk("f1_idle_valid", 32'(pix_valid_o), 32'd0);
        chk("f1_idle_busy", 32'(busy_o), 32'd0);
        chk("f1_idle_addr", 32'(disp_raddr_o), 32'd0);

        // Frame 2: random 30% ready, then a 50-cycle stall mid-line;
        // enable stays high so frame 3 follows directly.
        enable_i = 1'b1;
        step();
        k = 0;
        while (n < 3000 && k < 20000) begin
            pix_ready_i = ($urandom_range(0, 9) < 3);
            step();
            k++;
        end
        if (n < 3000) chk("timeout_random", 32'd0, 32'd1);
        pix_ready_i = 1'b1;
        wait_pix(5000, 4000, "timeout_stall_pt");
        pix_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        r0 = disp_raddr_o;
        chk("stall_valid", 32'(pix_valid_o), 32'd1);
        chk("stall_fifo2", 32'((int'(disp_raddr_o) + FRAME - n) % FRAME), 32'd2);
        for (int i = 0; i < 47; i++) begin
            step();
            chk("stall_addr", 32'(disp_raddr_o), 32'(r0));
        end
        pix_ready_i = 1'b1;
        wait_frames(2, FRAME + 100, "timeout_frame2");

        // Frame 3: back-to-back start, enable dropped mid-frame
        wait_pix(1000, 2000, "timeout_f3_start");
        chk("b2b_gap", 32'(sof_cyc - last_cyc), 32'd4);
        chk("f3_busy", 32'(busy_o), 32'd1);
        enable_i = 1'b0;
        wait_frames(3, FRAME + 100, "timeout_frame3");
        wait_idle(10, "f3_busy_fall");
        for (int i = 0; i < 20; i++) step();
        chk("f3_idle_valid", 32'(pix_valid_o), 32'd0);
        chk("f3_idle_addr", 32'(disp_raddr_o), 32'd0);

        // Frame 4: reset at pixel 300, then restart
        pulse_enable();
        wait_pix(300, 1000, "timeout_px300");
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(pix_valid_o), 32'd0);
        chk("mid_rst_addr", 32'(disp_raddr_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        step();
        pulse_enable();
        k = 0;
        while (!pix_valid_o && k < 10) begin
            step();
            k++;
        end
        chk("restart_valid", 32'(pix_valid_o), 32'd1);
        chk("restart_sof", 32'(pix_sof_o), 32'd1);
        chk("restart_data", 32'(pix_data_o), 32'h0000);
        wait_pix(200, 1000, "timeout_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
